// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding a DEPTH-entry circular queue toward the dispatcher.
// Optional build macro DC_ILLEGAL_CHECK_EN adds strict encoding checks and the DCDP_illegal output.
module decode_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  rdy_in,
  input  logic                  IFDC_en,
  input  logic [ADDR_WIDTH-1:0] IFDC_pc,
  input  logic [31:0]           IFDC_inst,
  input  logic                  IFDC_predict_result,
  output logic                  DCIF_full,
  input  logic                  RBDC_clear,
  input  logic                  DPDC_ready,
  output logic                  DCDP_en,
  output logic [ADDR_WIDTH-1:0] DCDP_pc,
  output logic [6:0]            DCDP_opcode,
  output logic [REG_WIDTH-1:0]  DCDP_rs1,
  output logic [REG_WIDTH-1:0]  DCDP_rs2,
  output logic [REG_WIDTH-1:0]  DCDP_rd,
  output logic [31:0]           DCDP_imm,
  output logic                  DCDP_predict_result
`ifdef DC_ILLEGAL_CHECK_EN
  ,
  output logic                  DCDP_illegal
`endif
);

  localparam logic [6:0] MAJ_LUI    = 7'b0110111;
  localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
  localparam logic [6:0] MAJ_JAL    = 7'b1101111;
  localparam logic [6:0] MAJ_JALR   = 7'b1100111;
  localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
  localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
  localparam logic [6:0] MAJ_STORE  = 7'b0100011;
  localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
  localparam logic [6:0] MAJ_OP     = 7'b0110011;

  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [6:0]            op;
    logic [REG_WIDTH-1:0]  rs1;
    logic [REG_WIDTH-1:0]  rs2;
    logic [REG_WIDTH-1:0]  rd;
    logic [31:0]           imm;
    logic                  pred;
`ifdef DC_ILLEGAL_CHECK_EN
    logic                  ill;
`endif
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  entry_t                wr_entry;
  logic [6:0]            dec_op;
  logic [31:0]           dec_imm;
  logic [2:0]            f3;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic                  push, pop;

  assign f3     = IFDC_inst[14:12];
  assign imm_i  = {{20{IFDC_inst[31]}}, IFDC_inst[31:20]};
  assign imm_s  = {{20{IFDC_inst[31]}}, IFDC_inst[31:25], IFDC_inst[11:7]};
  assign imm_b  = {{19{IFDC_inst[31]}}, IFDC_inst[31], IFDC_inst[7], IFDC_inst[30:25],
                   IFDC_inst[11:8], 1'b0};
  assign imm_u  = {IFDC_inst[31:12], 12'b0};
  assign imm_j  = {{11{IFDC_inst[31]}}, IFDC_inst[31], IFDC_inst[19:12], IFDC_inst[20],
                   IFDC_inst[30:21], 1'b0};
  assign imm_sh = {27'd0, IFDC_inst[24:20]};

  // Permissive decode: unknown funct3 values fall through to the last listed case.
  always_comb begin
    dec_op  = 7'd0;
    dec_imm = 32'd0;
    case (IFDC_inst[6:0])
      MAJ_LUI:   begin dec_op = 7'd1; dec_imm = imm_u; end
      MAJ_AUIPC: begin dec_op = 7'd2; dec_imm = imm_u; end
      MAJ_JAL:   begin dec_op = 7'd3; dec_imm = imm_j; end
      MAJ_JALR:  begin dec_op = 7'd4; dec_imm = imm_i; end
      MAJ_BRANCH: begin
        dec_imm = imm_b;
        case (f3)
          3'b000:  dec_op = 7'd5;
          3'b001:  dec_op = 7'd6;
          3'b100:  dec_op = 7'd7;
          3'b101:  dec_op = 7'd8;
          3'b110:  dec_op = 7'd9;
          default: dec_op = 7'd10;
        endcase
      end
      MAJ_LOAD: begin
        dec_imm = imm_i;
        case (f3)
          3'b000:  dec_op = 7'd11;
          3'b001:  dec_op = 7'd12;
          3'b010:  dec_op = 7'd13;
          3'b100:  dec_op = 7'd14;
          default: dec_op = 7'd15;
        endcase
      end
      MAJ_STORE: begin
        dec_imm = imm_s;
        case (f3)
          3'b000:  dec_op = 7'd16;
          3'b001:  dec_op = 7'd17;
          default: dec_op = 7'd18;
        endcase
      end
      MAJ_OPIMM: begin
        dec_imm = imm_i;
        case (f3)
          3'b000:  dec_op = 7'd19;
          3'b010:  dec_op = 7'd20;
          3'b011:  dec_op = 7'd21;
          3'b100:  dec_op = 7'd22;
          3'b110:  dec_op = 7'd23;
          3'b111:  dec_op = 7'd24;
          3'b001:  begin dec_op = 7'd25; dec_imm = imm_sh; end
          default: begin dec_op = IFDC_inst[30] ? 7'd27 : 7'd26; dec_imm = imm_sh; end
        endcase
      end
      MAJ_OP: begin
        case (f3)
          3'b000:  dec_op = IFDC_inst[30] ? 7'd29 : 7'd28;
          3'b001:  dec_op = 7'd30;
          3'b010:  dec_op = 7'd31;
          3'b011:  dec_op = 7'd32;
          3'b100:  dec_op = 7'd33;
          3'b101:  dec_op = IFDC_inst[30] ? 7'd35 : 7'd34;
          3'b110:  dec_op = 7'd36;
          default: dec_op = 7'd37;
        endcase
      end
      default: ;
    endcase
  end

`ifdef DC_ILLEGAL_CHECK_EN
  function automatic logic illegal_enc(input logic [31:0] inst);
    logic [2:0] fn3;
    logic [6:0] fn7;
    fn3 = inst[14:12];
    fn7 = inst[31:25];
    case (inst[6:0])
      MAJ_LUI, MAJ_AUIPC, MAJ_JAL, MAJ_JALR: illegal_enc = 1'b0;
      MAJ_BRANCH: illegal_enc = (fn3 == 3'b010) || (fn3 == 3'b011);
      MAJ_LOAD:   illegal_enc = (fn3 == 3'b011) || (fn3[2:1] == 2'b11);
      MAJ_STORE:  illegal_enc = (fn3 >= 3'b011);
      MAJ_OPIMM: begin
        if (fn3 == 3'b001)      illegal_enc = (fn7 != 7'h00);
        else if (fn3 == 3'b101) illegal_enc = (fn7 != 7'h00) && (fn7 != 7'h20);
        else                    illegal_enc = 1'b0;
      end
      MAJ_OP: illegal_enc = !((fn7 == 7'h00) ||
                              ((fn7 == 7'h20) && ((fn3 == 3'b000) || (fn3 == 3'b101))));
      default: illegal_enc = 1'b1;
    endcase
  endfunction
`endif

  always_comb begin
    wr_entry.pc   = IFDC_pc;
    wr_entry.op   = dec_op;
    wr_entry.rs1  = REG_WIDTH'(IFDC_inst[19:15]);
    wr_entry.rs2  = REG_WIDTH'(IFDC_inst[24:20]);
    wr_entry.rd   = REG_WIDTH'(IFDC_inst[11:7]);
    wr_entry.imm  = dec_imm;
    wr_entry.pred = IFDC_predict_result;
`ifdef DC_ILLEGAL_CHECK_EN
    wr_entry.ill  = illegal_enc(IFDC_inst);
    if (wr_entry.ill) begin
      wr_entry.op  = 7'd0;
      wr_entry.imm = 32'd0;
    end
`endif
  end

  assign DCIF_full = (count_q == CNT_FULL);
  assign DCDP_en   = (count_q != '0);
  assign push      = rdy_in && !RBDC_clear && IFDC_en && !DCIF_full;
  assign pop       = rdy_in && !RBDC_clear && DCDP_en && DPDC_ready;

  // Global ready low freezes everything, including a pending flush.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && RBDC_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = wr_entry;
        tail_d        = tail_q + PTR_ONE;
      end
      if (pop) head_d = head_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign DCDP_pc             = mem_q[head_q].pc;
  assign DCDP_opcode         = mem_q[head_q].op;
  assign DCDP_rs1            = mem_q[head_q].rs1;
  assign DCDP_rs2            = mem_q[head_q].rs2;
  assign DCDP_rd             = mem_q[head_q].rd;
  assign DCDP_imm            = mem_q[head_q].imm;
  assign DCDP_predict_result = mem_q[head_q].pred;
`ifdef DC_ILLEGAL_CHECK_EN
  assign DCDP_illegal        = mem_q[head_q].ill;
`endif

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered decode stage with a parametrised instruction queue between the instruction fetcher and the dispatcher. It accepts raw 32-bit RV32I instructions from IF and decodes them into the internal opcode numbering, 1 = lui through 37 = and, with 0 = invalid. Decoded fields are stored in a DEPTH-entry circular FIFO and presented to the dispatcher under a valid/ready handshake. It adds backpressure to IF and a single-cycle flush on branch misprediction.

## Interface
- ADDR_WIDTH, 32, PC width
- REG_WIDTH, 5, register index width
- DEPTH, 4, queue entries; power of two, ≥2
- PTR_WIDTH, 2, log2(DEPTH)
- clk_in  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- IFDC_en  input  1  IF presents an instruction this cycle
- IFDC_pc  input  ADDR_WIDTH  instruction PC
- IFDC_inst  input  32  raw instruction
- IFDC_predict_result  input  1  0 = not taken, 1 = taken
- DCIF_full  output  1  queue full; IF must hold
- RBDC_clear  input  1  misprediction flush
- DPDC_ready  input  1  dispatcher accepts head this cycle
- DCDP_en  output  1  head valid
- DCDP_pc  output  ADDR_WIDTH  head PC
- DCDP_opcode  output  7  internal opcode, 0..37
- DCDP_rs1, DCDP_rs2, DCDP_rd  output  REG_WIDTH each  inst[19:15], [24:20], [11:7]
- DCDP_imm  output  32  decoded immediate
- DCDP_predict_result  output  1  stored prediction
- DCDP_illegal  output  1  only with DC_ILLEGAL_CHECK_EN

## Operation
- Decode happens combinationally at enqueue; the queue stores decoded fields, not raw bits.
- Opcode mapping uses major opcode plus funct3, and inst[30] for sub/sra/srai.
- Unknown major opcode maps to 0.
- Immediates:
  - U-type: {inst[31:12], 12'b0}
  - J-type: sign-extended, bit0 = 0
  - B-type: sign-extended, bit0 = 0
  - I-type (jalr/loads/ALU-imm): sext(inst[31:20])
  - S-type: sext({inst[31:25], inst[11:7]})
  - slli/srli/srai: zero-extended inst[24:20]
  - opcode 0: imm = 0
- Push: IFDC_en && !DCIF_full && !RBDC_clear && rdy_in. Entry is written at the tail; tail increments mod DEPTH.
- Pop: DCDP_en && DPDC_ready && !RBDC_clear && rdy_in. Head increments mod DEPTH.
- Count, PTR_WIDTH+1 bits: +1 on push only, −1 on pop only, unchanged on both.
- DCIF_full = (count == DEPTH). It does not credit a same-cycle pop.
- DCDP_en = (count != 0). All DCDP_* outputs are driven from the head entry.
- IFDC_en while full is ignored; queue and count are unchanged.
- RBDC_clear:
  - head, tail and count go to 0 next edge.
  - A concurrent push or pop is discarded.
  - Clear has priority over everything except reset.
- rdy_in low: no pointer, count or entry change; outputs hold.

## Timing
- Reset (async assert, sync release): head = tail = count = 0; DCDP_en = 0; DCIF_full = 0; DCDP_* data = 0; DCDP_illegal = 0.
- Latency: a push at edge N into an empty queue gives DCDP_en = 1 with its fields after edge N (visible cycle N+1). There is no combinational IF→DP path.
- Throughput: one push and one pop per cycle sustained.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble.
- Full + pop, no push: DCIF_full deasserts the following cycle.
- Empty + push + DPDC_ready high: no pop that cycle, because DCDP_en is 0.
- Reset mid-operation clears all entries immediately; no partial state survives.

## Configuration
- DC_ILLEGAL_CHECK_EN defined:
  - DCDP_illegal port exists.
  - Unsupported encodings store opcode 0, imm 0, illegal = 1:
    - unknown major opcode
    - branch funct3 010/011
    - load funct3 011/110/111
    - store funct3 ≥ 011
    - slli/srli/srai with inst[31:25] ∉ {0000000, 0100000 (srli/srai only)}
    - R-type funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101}
  - These entries are still queued in order.
- Not defined:
  - Port is absent.
  - Unknown funct3 falls through: branch → bgeu, load → lhu, store → sw, OP-IMM funct3 101 → srli unless inst[30]. Funct7 is otherwise ignored.
  - Unknown major opcode still maps to 0.

## Test plan
- Reset, then push addi x1,x2,-1 (0xFFF10093) at pc 0x100 → next cycle DCDP_en = 1, opcode 19, rs1 = 2, rd = 1, imm = 0xFFFFFFFF, pc = 0x100.
- DPDC_ready = 0, push DEPTH instructions → DCIF_full = 1 after the DEPTH-th push. An extra IFDC_en is ignored; draining returns all DEPTH entries in order with no duplicates.
- Continuous push/pop over 3×DEPTH instructions (beq, lui 0x12345, jal −4, sw, srai 5) → in-order output, 1/cycle. Check lui imm = 0x12345000, jal imm = 0xFFFFFFFC, srai opcode 27, imm = 5.
- Queue holding 3 entries; RBDC_clear with simultaneous IFDC_en and DPDC_ready → next cycle DCDP_en = 0, count 0. The next push appears alone.
- rdy_in = 0 for 5 cycles with pushes and DPDC_ready high → no state change; resume is identical to the unstalled sequence.
- With DC_ILLEGAL_CHECK_EN, push a load with funct3 = 011 → opcode 0, imm 0, illegal = 1. Without the macro → opcode 15 (lhu).
